ddr_req_arbiter: RTL and testbench
==================================

# ddr_req_arbiter

Two-client command arbiter and sequencer in front of `ddr_sdram`. It accepts independent read/write burst requests from two requesters and grants them round-robin. It drives the controller's level-style `WRITE`/`READ` command inputs and address/length fields, and tracks `BUSY` to retire each command. It sits between the user-side clients and the `ddr_sdram` command port, and replaces the ad-hoc toggle handshakes currently used to launch commands.

## Interface
- `BURST_LENGTH`, 8, controller burst length in 16-bit words; must match `ddr_sdram`.
- `TIMEOUT_CYCLES`, 64, issue watchdog limit in clock cycles; used only with `DDR_ARB_TIMEOUT_EN`.

- `SYS_CLK_100M`  in  1  sole clock; all logic on the rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `REQ0`/`REQ1`  in  1  client request, level.
- `RW0`/`RW1`  in  1  1 = write, 0 = read.
- `BA0`/`BA1`  in  2  bank.
- `ROW0`/`ROW1`  in  13  row address.
- `COL0`/`COL1`  in  10  column address.
- `LEN0`/`LEN1`  in  4  write length code passed to `WRITE_LENGTH`.
- `GNT0`/`GNT1`  out  1  one-cycle pulse; fields captured this cycle.
- `DONE0`/`DONE1`  out  1  one-cycle pulse; command retired.
- `WRITE`, `READ`  out  1  controller command strobes, level.
- `BA_IN`  out  2; `ADDR_ROW_IN`  out  13; `ADDR_COL_IN`  out  10; `WRITE_LENGTH`  out  4  command fields to the controller.
- `BUSY`  in  1  controller busy.
- `OWNER`  out  1  index of the client that currently holds the grant.
- `ERR`  out  1  one-cycle pulse on watchdog abort.

## Operation
- States: IDLE, ISSUE, ACTIVE.
- IDLE: arbitration runs only when `BUSY`=0 and at least one `REQx`=1.
  - Single requester wins outright.
  - Both requesting: the winner is the client other than `LAST` (last-served pointer).
  - On a win, register the winner's fields, set `OWNER`, pulse `GNTx`, assert `WRITE` (RW=1) or `READ` (RW=0), and go to ISSUE.
- ISSUE: hold the strobe and all fields stable until `BUSY`=1 is sampled. Then deassert the strobe and go to ACTIVE.
- ACTIVE: fields stay stable. When `BUSY`=0 is sampled, pulse `DONEx` for `OWNER`, set `LAST`=`OWNER`, and go to IDLE.
- `WRITE` and `READ` are never high together. Both are 0 outside ISSUE.
- `WRITE_LENGTH` = min(`LENx`, `BURST_LENGTH`-1), a 4-bit unsigned compare. For reads it is driven as `BURST_LENGTH`-1.
- Client contract:
  - Fields must be stable while `REQx`=1 and until `GNTx` is received.
  - Fields are don't-care after `GNTx`.
  - `REQx` still high in IDLE after `DONEx` counts as a new request.
- Reset: state IDLE, `LAST`=1 (so client 0 wins the first tie). All outputs are 0: `GNT*`, `DONE*`, `WRITE`, `READ`, `BA_IN`, `ADDR_ROW_IN`, `ADDR_COL_IN`, `WRITE_LENGTH`, `OWNER`, `ERR`.
- Reset mid-command: outputs return to 0 on the next edge and no `DONE` is issued. No new grant is made until `BUSY`=0 is sampled.

## Timing
- `REQx` sampled at edge N (IDLE, `BUSY`=0): `GNTx`, strobe and fields are valid after edge N+1.
- `BUSY`=1 sampled at edge M: strobe is low after edge M+1.
- `BUSY`=0 sampled at edge K in ACTIVE: `DONEx` is high for one cycle after edge K+1, and the state is IDLE.
- Earliest next grant is after edge K+2, giving a minimum turnaround of 2 cycles.
- `BUSY` already high when ISSUE is entered: the strobe drops after the following edge. The strobe is always high for at least one cycle.
- Simultaneous `REQ0`/`REQ1` on consecutive commands: the grants alternate 0,1,0,1.
- A request arriving during ISSUE/ACTIVE waits. Nothing is queued beyond the level `REQ`.

## Configuration
- `DDR_ARB_TIMEOUT_EN` defined:
  - A counter runs in ISSUE, cleared on entry.
  - If `BUSY` stays 0 for `TIMEOUT_CYCLES` cycles, the block drops the strobe, pulses `DONEx` and `ERR` together, sets `LAST`=`OWNER`, and returns to IDLE.
- Not defined:
  - ISSUE waits indefinitely.
  - `ERR` is tied 0 and no counter is built.

## Test plan
- Reset: `RST`=1 for 3 cycles with `REQ0`=1 -> all outputs 0. `GNT0` is pulsed one cycle after `RST` falls.
- Single write: `REQ0`=1, `RW0`=1, `BA0`=2, `ROW0`=0x1ABC, `COL0`=0x3F8, `LEN0`=6; `BUSY` rises 3 cycles after `WRITE` and stays high 20 cycles.
  - `WRITE`=1 for exactly 4 cycles.
  - Fields stable until `DONE0`.
  - `WRITE_LENGTH`=6.
  - `DONE0` one cycle after `BUSY` falls.
- Contention: `REQ0`=`REQ1`=1 held for 4 commands -> grant order 0,1,0,1. `READ`/`WRITE` follow each `RWx`, and the two are never both high.
- Clamp and read: `REQ1`=1, `RW1`=0, `LEN1`=15 -> `READ`=1 and `WRITE_LENGTH`=7. With `RW1`=1 and `LEN1`=15 -> `WRITE_LENGTH`=7.
- Mid-operation reset: assert `RST` during ACTIVE -> strobe and fields are 0 next cycle with no `DONE`. While `BUSY` is still 1, no grant is made despite `REQ0`=1.
- Watchdog (`DDR_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16): `BUSY` held 0 -> `WRITE` drops and `DONE0`+`ERR` pulse 16 cycles after `GNT0`. Without the macro, `WRITE` stays high.

Source files
------------

// File: rtl/ddr_req_arbiter_if.sv
// ddr_req_arbiter bus bundle: client request fields
// plus the ddr_sdram command port, grouped by side.
interface ddr_req_arbiter_if;
  logic        REQ0, REQ1;
  logic        RW0, RW1;
  logic [1:0]  BA0, BA1;
  logic [12:0] ROW0, ROW1;
  logic [9:0]  COL0, COL1;
  logic [3:0]  LEN0, LEN1;
  logic        GNT0, GNT1;
  logic        DONE0, DONE1;
  logic        WRITE, READ;
  logic [1:0]  BA_IN;
  logic [12:0] ADDR_ROW_IN;
  logic [9:0]  ADDR_COL_IN;
  logic [3:0]  WRITE_LENGTH;
  logic        BUSY;
  logic        OWNER;
  logic        ERR;

  modport master (
    input  REQ0, REQ1, RW0, RW1, BA0, BA1,
    input  ROW0, ROW1, COL0, COL1, LEN0, LEN1,
    input  BUSY,
    output GNT0, GNT1, DONE0, DONE1,
    output WRITE, READ, BA_IN, ADDR_ROW_IN,
    output ADDR_COL_IN, WRITE_LENGTH,
    output OWNER, ERR
  );

  modport slave (
    output REQ0, REQ1, RW0, RW1, BA0, BA1,
    output ROW0, ROW1, COL0, COL1, LEN0, LEN1,
    output BUSY,
    input  GNT0, GNT1, DONE0, DONE1,
    input  WRITE, READ, BA_IN, ADDR_ROW_IN,
    input  ADDR_COL_IN, WRITE_LENGTH,
    input  OWNER, ERR
  );
endinterface

// File: rtl/ddr_req_arbiter.sv
// Two-client round-robin command arbiter for ddr_sdram.
// Optional issue watchdog: define DDR_ARB_TIMEOUT_EN.
module ddr_req_arbiter #(
  parameter int BURST_LENGTH   = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic             SYS_CLK_100M,
  input logic             RST,
  ddr_req_arbiter_if.master bus
);

  localparam logic [3:0] LEN_MAX = 4'(BURST_LENGTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t      state_q;
  logic        last_q, owner_q;
  logic        gnt0_q, gnt1_q;
  logic        done0_q, done1_q;
  logic        write_q, read_q;
  logic [1:0]  ba_q;
  logic [12:0] row_q;
  logic [9:0]  col_q;
  logic [3:0]  wlen_q;

  logic        arb_d, win_d, rw_d;
  logic [1:0]  ba_d;
  logic [12:0] row_d;
  logic [9:0]  col_d;
  logic [3:0]  len_d, wlen_d;

`ifdef DDR_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt_q;
  logic          err_q;
`endif

  // Winner selection and field mux for the pending grant
  always_comb begin
    arb_d  = (state_q == IDLE) && !bus.BUSY
             && (bus.REQ0 || bus.REQ1);
    win_d  = (bus.REQ0 && bus.REQ1) ? ~last_q : bus.REQ1;
    rw_d   = win_d ? bus.RW1  : bus.RW0;
    ba_d   = win_d ? bus.BA1  : bus.BA0;
    row_d  = win_d ? bus.ROW1 : bus.ROW0;
    col_d  = win_d ? bus.COL1 : bus.COL0;
    len_d  = win_d ? bus.LEN1 : bus.LEN0;
    wlen_d = LEN_MAX;
    if (rw_d && (len_d < LEN_MAX)) wlen_d = len_d;
  end

  // Command sequencer: grant, hold strobe until BUSY, retire
  always_ff @(posedge SYS_CLK_100M) begin
    if (RST) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      write_q <= 1'b0;
      read_q  <= 1'b0;
      ba_q    <= '0;
      row_q   <= '0;
      col_q   <= '0;
      wlen_q  <= '0;
`ifdef DDR_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
`ifdef DDR_ARB_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
          if (arb_d) begin
            state_q <= ISSUE;
            owner_q <= win_d;
            gnt0_q  <= ~win_d;
            gnt1_q  <= win_d;
            write_q <= rw_d;
            read_q  <= ~rw_d;
            ba_q    <= ba_d;
            row_q   <= row_d;
            col_q   <= col_d;
            wlen_q  <= wlen_d;
`ifdef DDR_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end
        ISSUE: begin
          if (bus.BUSY) begin
            write_q <= 1'b0;
            read_q  <= 1'b0;
            state_q <= ACTIVE;
          end
`ifdef DDR_ARB_TIMEOUT_EN
          else if (cnt_q == CNT_MAX) begin
            write_q <= 1'b0;
            read_q  <= 1'b0;
            done0_q <= ~owner_q;
            done1_q <= owner_q;
            err_q   <= 1'b1;
            last_q  <= owner_q;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        ACTIVE: begin
          if (!bus.BUSY) begin
            done0_q <= ~owner_q;
            done1_q <= owner_q;
            last_q  <= owner_q;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.GNT0         = gnt0_q;
  assign bus.GNT1         = gnt1_q;
  assign bus.DONE0        = done0_q;
  assign bus.DONE1        = done1_q;
  assign bus.WRITE        = write_q;
  assign bus.READ         = read_q;
  assign bus.BA_IN        = ba_q;
  assign bus.ADDR_ROW_IN  = row_q;
  assign bus.ADDR_COL_IN  = col_q;
  assign bus.WRITE_LENGTH = wlen_q;
  assign bus.OWNER        = owner_q;
`ifdef DDR_ARB_TIMEOUT_EN
  assign bus.ERR          = err_q;
`else
  assign bus.ERR          = 1'b0;
`endif

endmodule

// File: tb/tb_ddr_req_arbiter.sv
// Self-checking bench for ddr_req_arbiter: transaction-level
// reference model with randomized fields and BUSY timing.
module tb_ddr_req_arbiter;

  localparam int BL = 8;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ddr_req_arbiter_if bus();

  ddr_req_arbiter #(
    .BURST_LENGTH  (BL),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .SYS_CLK_100M(clk),
    .RST         (rst),
    .bus         (bus)
  );

  int errors = 0;
  int checks = 0;
  bit m_last;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [36:0] outs();
    return {bus.GNT0, bus.GNT1, bus.DONE0, bus.DONE1,
            bus.WRITE, bus.READ, bus.BA_IN, bus.ADDR_ROW_IN,
            bus.ADDR_COL_IN, bus.WRITE_LENGTH, bus.OWNER, bus.ERR};
  endfunction

  function automatic logic [28:0] flds();
    return {bus.BA_IN, bus.ADDR_ROW_IN,
            bus.ADDR_COL_IN, bus.WRITE_LENGTH};
  endfunction

  task automatic rand_client(input bit c);
    if (c) begin
      bus.RW1  = 1'($urandom);
      bus.BA1  = 2'($urandom);
      bus.ROW1 = 13'($urandom);
      bus.COL1 = 10'($urandom);
      bus.LEN1 = 4'($urandom);
    end else begin
      bus.RW0  = 1'($urandom);
      bus.BA0  = 2'($urandom);
      bus.ROW0 = 13'($urandom);
      bus.COL0 = 10'($urandom);
      bus.LEN0 = 4'($urandom);
    end
  endtask

  // One command: grant on the next edge, BUSY rises d cycles
  // after the grant and stays high l cycles (l >= 1).
  task automatic run_cmd(input int d, input int l);
    bit          w, rw;
    int          len;
    logic [3:0]  wl;
    logic [28:0] ef;
    w   = (bus.REQ0 && bus.REQ1) ? !m_last : bus.REQ1;
    rw  = w ? bus.RW1 : bus.RW0;
    len = int'(w ? bus.LEN1 : bus.LEN0);
    wl  = rw ? 4'((len < BL - 1) ? len : BL - 1) : 4'(BL - 1);
    ef  = w ? {bus.BA1, bus.ROW1, bus.COL1, wl}
            : {bus.BA0, bus.ROW0, bus.COL0, wl};
    @(posedge clk); #1;
    chk("gnt", {bus.GNT1, bus.GNT0}, w ? 2'b10 : 2'b01);
    chk("owner", bus.OWNER, w);
    chk("strobe", {bus.WRITE, bus.READ}, {rw, !rw});
    chk("fields", flds(), ef);
    chk("done_g", {bus.DONE1, bus.DONE0, bus.ERR}, 3'b000);
    bus.BUSY = (d == 0);
    rand_client(w);
    for (int k = 1; k <= d + l + 1; k++) begin
      @(posedge clk); #1;
      chk("strobe_k", {bus.WRITE, bus.READ},
          (k <= d) ? {rw, !rw} : 2'b00);
      chk("gnt_k", {bus.GNT1, bus.GNT0}, 2'b00);
      chk("done_k", {bus.DONE1, bus.DONE0, bus.ERR},
          (k == d + l + 1) ? (w ? 3'b100 : 3'b010) : 3'b000);
      chk("hold_k", flds(), ef);
      chk("owner_k", bus.OWNER, w);
      bus.BUSY = (k >= d) && (k < d + l);
    end
    m_last = w;
  endtask

  initial begin
    bit p0, p1;
    int r;
    rst = 1'b1;
    bus.BUSY = 1'b0;
    bus.REQ0 = 1'b0;
    bus.REQ1 = 1'b0;
    rand_client(0);
    rand_client(1);
    m_last = 1'b1;

    // reset with REQ0 pending, then the single write
    bus.REQ0 = 1'b1;
    bus.RW0  = 1'b1;
    bus.BA0  = 2'd2;
    bus.ROW0 = 13'h1ABC;
    bus.COL0 = 10'h3F8;
    bus.LEN0 = 4'd6;
    repeat (3) begin
      @(posedge clk); #1;
      chk("reset", outs(), '0);
    end
    rst = 1'b0;
    run_cmd(3, 20);
    bus.REQ0 = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("idle", {bus.GNT1, bus.GNT0, bus.WRITE, bus.READ}, 4'h0);
    end

    // contention: both held for four commands
    rand_client(0);
    rand_client(1);
    bus.REQ0 = 1'b1;
    bus.REQ1 = 1'b1;
    repeat (4) run_cmd($urandom_range(0, 3), $urandom_range(1, 5));

    // read forces full burst; write length clamps
    bus.REQ0 = 1'b0;
    bus.RW1  = 1'b0;
    bus.LEN1 = 4'd15;
    run_cmd(1, 2);
    bus.RW1  = 1'b1;
    bus.LEN1 = 4'd15;
    run_cmd(0, 1);
    bus.REQ1 = 1'b0;

    // random request patterns
    repeat (20) begin
      r  = $urandom_range(1, 3);
      p0 = bus.REQ0;
      p1 = bus.REQ1;
      bus.REQ0 = r[0];
      bus.REQ1 = r[1];
      if (!p0) rand_client(0);
      if (!p1) rand_client(1);
      run_cmd($urandom_range(0, 4), $urandom_range(1, 6));
    end
    bus.REQ0 = 1'b0;
    bus.REQ1 = 1'b0;
    @(posedge clk); #1;

    // reset during ACTIVE
    rand_client(0);
    bus.REQ0 = 1'b1;
    @(posedge clk); #1;
    chk("mr_gnt", {bus.GNT1, bus.GNT0}, 2'b01);
    bus.BUSY = 1'b1;
    @(posedge clk); #1;
    chk("mr_act", {bus.WRITE, bus.READ}, 2'b00);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mr_rst", outs(), '0);
    rst = 1'b0;
    m_last = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      chk("mr_hold", {bus.GNT1, bus.GNT0, bus.DONE1, bus.DONE0},
          4'h0);
    end
    bus.BUSY = 1'b0;
    run_cmd(2, 3);

    // watchdog: BUSY never rises
    bus.REQ0 = 1'b1;
    bus.REQ1 = 1'b0;
    bus.RW0  = 1'b1;
    @(posedge clk); #1;
    chk("wd_gnt", {bus.GNT0, bus.WRITE}, 2'b11);
    bus.REQ0 = 1'b0;
`ifdef DDR_ARB_TIMEOUT_EN
    for (int k = 1; k <= TO; k++) begin
      @(posedge clk); #1;
      chk("wd_wr", bus.WRITE, (k < TO));
      chk("wd_end", {bus.DONE0, bus.ERR},
          (k == TO) ? 2'b11 : 2'b00);
    end
`else
    for (int k = 1; k <= 2 * TO; k++) begin
      @(posedge clk); #1;
      chk("wd_wr", bus.WRITE, 1'b1);
      chk("wd_end", {bus.DONE0, bus.ERR}, 2'b00);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
